// File: rtl/dds_sweep_ctrl_pkg.sv
// Shared state encoding for the DDS sweep sequencer.
package dds_sweep_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StUp   = 2'd1,
    StDn   = 2'd2,
    StDone = 2'd3
  } sweep_state_e;

endpackage

// File: rtl/dds_sweep_ctrl_dwell_timer.sv
// Dwell counter: clears on load, increments on enable, flags when it reaches limit.
module dds_sweep_ctrl_dwell_timer #(
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          en,
  input  logic [DW-1:0] limit,
  output logic [DW-1:0] cnt,
  output logic          tc
);

  logic [DW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == limit);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Linear / triangle frequency-sweep sequencer driving the DDS core K and P words.
module dds_sweep_ctrl
  import dds_sweep_ctrl_pkg::*;
#(
  parameter int unsigned KW = 32,
  parameter int unsigned PW = 11,
  parameter int unsigned NW = 16,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic          mode,
  input  logic [KW-1:0] k_start,
  input  logic [KW-1:0] k_step,
  input  logic [NW-1:0] n_steps,
  input  logic [DW-1:0] dwell,
  input  logic [PW-1:0] p_offset,
  output logic [KW-1:0] K,
  output logic [PW-1:0] P,
  output logic          step_stb,
  output logic          busy,
  output logic          done
);

  sweep_state_e  state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [PW-1:0] p_q, p_d;
  logic          stb_q, stb_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [NW-1:0] step_cnt_q, step_cnt_d;

  logic [KW-1:0] cfg_step_q;
  logic [NW-1:0] cfg_n_q;
  logic [DW-1:0] cfg_dwell_q;
  logic          cfg_mode_q;
  logic          cfg_load;

  logic          tmr_load, tmr_en, tmr_tc;
  logic [DW-1:0] tmr_cnt;

  dds_sweep_ctrl_dwell_timer #(
    .DW (DW)
  ) u_dwell_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tmr_load),
    .en    (tmr_en),
    .limit (cfg_dwell_q),
    .cnt   (tmr_cnt),
    .tc    (tmr_tc)
  );

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    p_d        = p_q;
    stb_d      = 1'b0;
    step_cnt_d = step_cnt_q;
    cfg_load   = 1'b0;
    tmr_load   = 1'b0;
    tmr_en     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          cfg_load   = 1'b1;
          k_d        = k_start;
          p_d        = p_offset;
          stb_d      = 1'b1;
          step_cnt_d = '0;
          tmr_load   = 1'b1;
          state_d    = StUp;
        end
      end
      StUp, StDn: begin
        if (abort) begin
          state_d = StIdle;
        end else if (!tmr_tc) begin
          tmr_en = 1'b1;
        end else if (step_cnt_q < cfg_n_q) begin
          k_d        = (state_q == StUp) ? k_q + cfg_step_q : k_q - cfg_step_q;
          step_cnt_d = step_cnt_q + 1'b1;
          stb_d      = 1'b1;
          tmr_load   = 1'b1;
        end else if (state_q == StUp && cfg_mode_q && cfg_n_q != '0) begin
          // Turn-around: the peak was already the last UP value, so DN starts one step below.
          k_d        = k_q - cfg_step_q;
          step_cnt_d = NW'(1);
          stb_d      = 1'b1;
          tmr_load   = 1'b1;
          state_d    = StDn;
        end else begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d == StUp) || (state_d == StDn);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      k_q        <= '0;
      p_q        <= '0;
      stb_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      step_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      p_q        <= p_d;
      stb_q      <= stb_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      step_cnt_q <= step_cnt_d;
    end
  end

  // Config is frozen for the whole sweep; host writes mid-sweep are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_step_q  <= '0;
      cfg_n_q     <= '0;
      cfg_dwell_q <= '0;
      cfg_mode_q  <= 1'b0;
    end else if (cfg_load) begin
      cfg_step_q  <= k_step;
      cfg_n_q     <= n_steps;
      cfg_dwell_q <= dwell;
      cfg_mode_q  <= mode;
    end
  end

  assign K        = k_q;
  assign P        = p_q;
  assign step_stb = stb_q;
  assign busy     = busy_q;
  assign done     = done_q;

  logic unused_tmr;
  assign unused_tmr = ^tmr_cnt;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl with a per-cycle expected-output scoreboard.
module tb_dds_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        mode = 1'b0;
  logic [31:0] k_start = '0;
  logic [31:0] k_step = '0;
  logic [15:0] n_steps = '0;
  logic [15:0] dwell = '0;
  logic [10:0] p_offset = '0;
  logic [31:0] K;
  logic [10:0] P;
  logic        step_stb, busy, done;

  typedef struct packed {
    logic [31:0] k;
    logic [10:0] p;
    logic        stb;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] last_k = '0;
  logic [10:0] last_p = '0;

  always #5 clk = ~clk;

  dds_sweep_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .mode     (mode),
    .k_start  (k_start),
    .k_step   (k_step),
    .n_steps  (n_steps),
    .dwell    (dwell),
    .p_offset (p_offset),
    .K        (K),
    .P        (P),
    .step_stb (step_stb),
    .busy     (busy),
    .done     (done)
  );

  task automatic push_hold(input logic [31:0] k, input logic [10:0] p, input int d);
    for (int c = 0; c <= d; c++) sb.push_back('{k, p, (c == 0), 1'b1, 1'b0});
  endtask

  // Enumerate the K sequence the sweep must produce, then the done and idle cycles.
  task automatic push_sweep(input logic [31:0] ks, input logic [31:0] st, input int n,
                            input int d, input logic m, input logic [10:0] po);
    logic [31:0] k;
    k = ks;
    for (int i = 0; i <= n; i++) begin
      push_hold(k, po, d);
      if (i < n) k = k + st;
    end
    if (m && n != 0) begin
      for (int i = 1; i <= n; i++) begin
        k = k - st;
        push_hold(k, po, d);
      end
    end
    sb.push_back('{k, po, 1'b0, 1'b0, 1'b1});
    sb.push_back('{k, po, 1'b0, 1'b0, 1'b0});
    last_k = k;
    last_p = po;
  endtask

  task automatic push_idle(input int cnt);
    for (int i = 0; i < cnt; i++) sb.push_back('{last_k, last_p, 1'b0, 1'b0, 1'b0});
  endtask

  task automatic run_n(input string tag, input int cnt);
    exp_t e, o;
    for (int i = 0; i < cnt; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $error("FAIL %s: scoreboard empty at cycle %0d, required an entry", tag, i);
      end else begin
        e = sb.pop_front();
        o = '{K, P, step_stb, busy, done};
        assert (o === e) else begin
          errors++;
          $error("FAIL %s[%0d]: got K=%h P=%h stb=%b busy=%b done=%b, required K=%h P=%h stb=%b busy=%b done=%b",
                 tag, i, o.k, o.p, o.stb, o.busy, o.done, e.k, e.p, e.stb, e.busy, e.done);
        end
      end
    end
  endtask

  task automatic run_all(input string tag);
    run_n(tag, sb.size());
  endtask

  task automatic set_cfg(input logic [31:0] ks, input logic [31:0] st, input logic [15:0] n,
                         input logic [15:0] d, input logic m, input logic [10:0] po);
    k_start = ks; k_step = st; n_steps = n; dwell = d; mode = m; p_offset = po;
  endtask

  initial begin
    // Reset state
    #1;
    checks++;
    assert ({K, P, step_stb, busy, done} === 46'd0) else begin
      errors++;
      $error("FAIL reset: got K=%h P=%h stb=%b busy=%b done=%b, required all 0",
             K, P, step_stb, busy, done);
    end
    #11 rst_n = 1'b1;
    push_idle(2);
    run_n("idle", 2);

    // 1: up-only
    set_cfg(32'd100, 32'd10, 16'd3, 16'd2, 1'b0, 11'h155);
    push_sweep(32'd100, 32'd10, 3, 2, 1'b0, 11'h155);
    start = 1'b1;
    run_n("up", 1);
    start = 1'b0;
    set_cfg(32'd1, 32'd1, 16'd9, 16'd9, 1'b1, 11'h0);
    run_all("up");

    // 2: triangle
    set_cfg(32'd100, 32'd10, 16'd3, 16'd2, 1'b1, 11'h2AA);
    push_sweep(32'd100, 32'd10, 3, 2, 1'b1, 11'h2AA);
    start = 1'b1;
    run_n("tri", 1);
    start = 1'b0;
    run_all("tri");

    // 3: wrap with dwell 0
    set_cfg(32'hFFFF_FFF0, 32'h20, 16'd1, 16'd0, 1'b0, 11'h7);
    push_sweep(32'hFFFF_FFF0, 32'h20, 1, 0, 1'b0, 11'h7);
    start = 1'b1;
    run_n("wrap", 1);
    start = 1'b0;
    run_all("wrap");

    // 4: abort in cycle 4, then immediate restart
    set_cfg(32'd100, 32'd10, 16'd3, 16'd2, 1'b0, 11'h3);
    push_sweep(32'd100, 32'd10, 3, 2, 1'b0, 11'h3);
    start = 1'b1;
    run_n("abort_pre", 1);
    start = 1'b0;
    run_n("abort_pre", 3);
    sb.delete();
    last_k = 32'd110;
    push_idle(3);
    abort = 1'b1;
    run_n("abort", 1);
    abort = 1'b0;
    run_n("abort_idle", 2);
    push_sweep(32'd100, 32'd10, 3, 2, 1'b0, 11'h3);
    start = 1'b1;
    run_n("restart", 1);
    start = 1'b0;
    run_all("restart");

    // 5a: single tone, mode ignored
    set_cfg(32'd4242, 32'd5, 16'd0, 16'd0, 1'b1, 11'h11);
    push_sweep(32'd4242, 32'd5, 0, 0, 1'b1, 11'h11);
    start = 1'b1;
    run_n("tone", 1);
    start = 1'b0;
    run_all("tone");

    // 5b: start with abort in IDLE does nothing
    set_cfg(32'd9, 32'd9, 16'd2, 16'd1, 1'b0, 11'h1);
    push_idle(3);
    start = 1'b1;
    abort = 1'b1;
    run_n("start_abort", 2);
    start = 1'b0;
    abort = 1'b0;
    run_n("start_abort", 1);

    // 5c: start while busy is ignored, config stays latched
    set_cfg(32'd500, 32'd5, 16'd2, 16'd1, 1'b0, 11'h22);
    push_sweep(32'd500, 32'd5, 2, 1, 1'b0, 11'h22);
    start = 1'b1;
    run_n("busy_start", 1);
    start = 1'b0;
    run_n("busy_start", 2);
    set_cfg(32'd7, 32'd999, 16'd1, 16'd5, 1'b1, 11'h0);
    start = 1'b1;
    run_n("busy_start", 1);
    start = 1'b0;
    run_all("busy_start");

    // 6: async reset mid-triangle
    set_cfg(32'd100, 32'd10, 16'd3, 16'd2, 1'b1, 11'h44);
    push_sweep(32'd100, 32'd10, 3, 2, 1'b1, 11'h44);
    start = 1'b1;
    run_n("rst_pre", 1);
    start = 1'b0;
    run_n("rst_pre", 5);
    sb.delete();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    assert ({K, P, step_stb, busy, done} === 46'd0) else begin
      errors++;
      $error("FAIL async_rst: got K=%h P=%h stb=%b busy=%b done=%b, required all 0",
             K, P, step_stb, busy, done);
    end
    #2 rst_n = 1'b1;
    last_k = '0;
    last_p = '0;
    push_idle(3);
    run_n("post_rst", 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
